// File: rtl/vga_frame_receiver_pkg.sv
// Shared VGA 640x480 timing definitions, also used by the VGA transmitter.
// Holds the frame geometry (800 x 521 total, sync windows), the receiver
// lock FSM encoding and a small wrapping-increment helper.
package vga_frame_receiver_pkg;

    localparam int unsigned COORD_W = 10;

    // Horizontal timing, in pixel clocks
    localparam logic [COORD_W-1:0] H_TOTAL      = 10'd800;
    localparam logic [COORD_W-1:0] H_VISIBLE    = 10'd640;
    localparam logic [COORD_W-1:0] H_SYNC_START = 10'd656;  // first low HSync column
    localparam logic [COORD_W-1:0] H_SYNC_END   = 10'd752;  // first high column after sync
    localparam logic [COORD_W-1:0] H_LAST       = H_TOTAL - 10'd1;

    // Vertical timing, in lines
    localparam logic [COORD_W-1:0] V_TOTAL      = 10'd521;
    localparam logic [COORD_W-1:0] V_VISIBLE    = 10'd480;
    localparam logic [COORD_W-1:0] V_SYNC_START = 10'd490;  // first low VSync row
    localparam logic [COORD_W-1:0] V_SYNC_END   = 10'd492;  // first high row after sync
    localparam logic [COORD_W-1:0] V_LAST       = V_TOTAL - 10'd1;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,   // waiting for an HSync falling edge
        ST_H_LOCK = 2'd1,   // line timing known, waiting for VSync at column 0
        ST_LOCKED = 2'd2    // full frame timing tracked
    } rx_state_e;

    function automatic logic [COORD_W-1:0] wrap_inc(input logic [COORD_W-1:0] v,
                                                    input logic [COORD_W-1:0] last);
        return (v == last) ? '0 : v + 10'd1;
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Column/row counters for the VGA receiver.
//   clk_i, rst_ni  : pixel clock, async active-low reset
//   en_i           : pixel-rate qualifier, counters hold when low
//   col_load_i     : force this sample's column to the HSync start column
//   row_load_i     : force this sample's row to the VSync start row
//   col_o, row_o   : coordinate of the current sample (load applied)
//   cnt_col_o/row_o: raw counter registers, free of the load muxes so the
//                    FSM can decide loads without a combinational loop
module vga_timing_counter
    import vga_frame_receiver_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               en_i,
    input  logic               col_load_i,
    input  logic               row_load_i,
    output logic [COORD_W-1:0] col_o,
    output logic [COORD_W-1:0] row_o,
    output logic [COORD_W-1:0] cnt_col_o,
    output logic [COORD_W-1:0] cnt_row_o
);

    logic [COORD_W-1:0] col_q, col_d;
    logic [COORD_W-1:0] row_q, row_d;

    assign col_o     = col_load_i ? H_SYNC_START : col_q;
    assign row_o     = row_load_i ? V_SYNC_START : row_q;
    assign cnt_col_o = col_q;
    assign cnt_row_o = row_q;

    // The registers always hold the coordinate of the next sample.
    always_comb begin
        col_d = wrap_inc(col_o, H_LAST);
        row_d = (col_o == H_LAST) ? wrap_inc(row_o, V_LAST) : row_o;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q <= '0;
            row_q <= '0;
        end else if (en_i) begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/vga_frame_receiver.sv
// VGA frame receiver: recovers column/row coordinates from active-low
// HSync/VSync, locks onto 800x521 timing and flags lock losses.
//   Clock, Reset          : pixel clock, async active-low reset
//   Enable                : pixel-rate qualifier, all state holds when low
//   iHorizontalSync/iVerticalSync : active-low syncs
//   iPixel                : {r,g,b} sample
//   oColumn, oRow         : coordinate of the previous sample (0 unless locked)
//   oPixel                : registered iPixel
//   oPixelValid           : locked and inside 640x480
//   oFrameStart           : pulse at (0,0) while locked
//   oLocked               : FSM in LOCKED
//   oErrorCount           : saturating count of lock losses
module vga_frame_receiver
    import vga_frame_receiver_pkg::*;
#(
    parameter int ERR_WIDTH = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic                 iHorizontalSync,
    input  logic                 iVerticalSync,
    input  logic [2:0]           iPixel,
    output logic [9:0]           oColumn,
    output logic [9:0]           oRow,
    output logic [2:0]           oPixel,
    output logic                 oPixelValid,
    output logic                 oFrameStart,
    output logic                 oLocked,
    output logic [ERR_WIDTH-1:0] oErrorCount
);

    rx_state_e state_q, state_d;

    logic hs_prev_q, vs_prev_q, primed_q;
    logic hs_fall, hs_rise, vs_fall;
    logic col_load, row_load, lock_err, locked_d;

    logic [COORD_W-1:0] smp_col, smp_row, cnt_col, cnt_row;

    logic [COORD_W-1:0]   col_out_q, row_out_q;
    logic [2:0]           pix_q;
    logic                 valid_q, fstart_q, locked_q;
    logic [ERR_WIDTH-1:0] err_q;

    // primed_q suppresses edges on the first enabled sample after reset.
    assign hs_fall = Enable & primed_q &  hs_prev_q & ~iHorizontalSync;
    assign hs_rise = Enable & primed_q & ~hs_prev_q &  iHorizontalSync;
    assign vs_fall = Enable & primed_q &  vs_prev_q & ~iVerticalSync;

    vga_timing_counter u_cnt (
        .clk_i      (Clock),
        .rst_ni     (Reset),
        .en_i       (Enable),
        .col_load_i (col_load),
        .row_load_i (row_load),
        .col_o      (smp_col),
        .row_o      (smp_row),
        .cnt_col_o  (cnt_col),
        .cnt_row_o  (cnt_row)
    );

    // Loads only happen in SEARCH/H_LOCK and the checks in those states read
    // the raw counters, which equal the sample coordinate there.
    always_comb begin
        state_d  = state_q;
        col_load = 1'b0;
        row_load = 1'b0;
        lock_err = 1'b0;
        if (Enable) begin
            case (state_q)
                ST_SEARCH: begin
                    if (hs_fall) begin
                        col_load = 1'b1;
                        state_d  = ST_H_LOCK;
                    end
                end
                ST_H_LOCK: begin
                    if (hs_fall && cnt_col != H_SYNC_START) begin
                        state_d = ST_SEARCH;
                    end else if (vs_fall && cnt_col == '0) begin
                        row_load = 1'b1;
                        state_d  = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    lock_err = (hs_fall && cnt_col != H_SYNC_START)
                            || (hs_rise && cnt_col != H_SYNC_END)
                            || (vs_fall && (cnt_row != V_SYNC_START || cnt_col != '0))
                            || (!iVerticalSync && (cnt_row < V_SYNC_START || cnt_row >= V_SYNC_END));
                    if (lock_err) state_d = ST_SEARCH;
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    assign locked_d = (state_d == ST_LOCKED);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_SEARCH;
            hs_prev_q <= 1'b1;
            vs_prev_q <= 1'b1;
            primed_q  <= 1'b0;
        end else if (Enable) begin
            state_q   <= state_d;
            hs_prev_q <= iHorizontalSync;
            vs_prev_q <= iVerticalSync;
            primed_q  <= 1'b1;
        end
    end

    // Outputs describe the sample just taken, using the post-decision state,
    // so an error sample already reports unlocked.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            col_out_q <= '0;
            row_out_q <= '0;
            pix_q     <= '0;
            valid_q   <= 1'b0;
            fstart_q  <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= '0;
        end else if (Enable) begin
            col_out_q <= locked_d ? smp_col : '0;
            row_out_q <= locked_d ? smp_row : '0;
            pix_q     <= iPixel;
            valid_q   <= locked_d && (smp_col < H_VISIBLE) && (smp_row < V_VISIBLE);
            fstart_q  <= locked_d && (smp_col == '0) && (smp_row == '0);
            locked_q  <= locked_d;
            if (lock_err && (err_q != {ERR_WIDTH{1'b1}}))
                err_q <= err_q + {{(ERR_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            valid_q  <= 1'b0;
            fstart_q <= 1'b0;
        end
    end

    assign oColumn     = col_out_q;
    assign oRow        = row_out_q;
    assign oPixel      = pix_q;
    assign oPixelValid = valid_q;
    assign oFrameStart = fstart_q;
    assign oLocked     = locked_q;
    assign oErrorCount = err_q;

endmodule

// File: tb/tb_vga_frame_receiver.sv
// Bench for vga_frame_receiver: a bench-side VGA source drives sync/pixel
// timing, a frame-level model predicts every output, and directed literal
// expectations pin the model at key points.
module tb_vga_frame_receiver;

    logic       Clock = 1'b0;
    logic       Reset, Enable, iHorizontalSync, iVerticalSync;
    logic [2:0] iPixel;
    logic [9:0] oColumn, oRow;
    logic [2:0] oPixel;
    logic       oPixelValid, oFrameStart, oLocked;
    logic [7:0] oErrorCount;

    int n_checks = 0;
    int n_errors = 0;

    vga_frame_receiver #(.ERR_WIDTH(8)) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .Enable          (Enable),
        .iHorizontalSync (iHorizontalSync),
        .iVerticalSync   (iVerticalSync),
        .iPixel          (iPixel),
        .oColumn         (oColumn),
        .oRow            (oRow),
        .oPixel          (oPixel),
        .oPixelValid     (oPixelValid),
        .oFrameStart     (oFrameStart),
        .oLocked         (oLocked),
        .oErrorCount     (oErrorCount)
    );

    always #5 Clock = ~Clock;

    // ---------------- frame-level model ----------------
    int m_lvl;          // 0 hunting for a line, 1 line found, 2 frame locked
    int m_col, m_row, m_err;
    bit m_ph, m_pv, m_primed;
    logic [9:0] e_col, e_row;
    logic [2:0] e_pix;
    logic       e_pv, e_fs, e_lk;
    logic [7:0] e_err;

    task automatic model_reset();
        m_lvl = 0; m_col = 0; m_row = 0; m_err = 0;
        m_ph = 1; m_pv = 1; m_primed = 0;
        e_col = '0; e_row = '0; e_pix = '0;
        e_pv = 0; e_fs = 0; e_lk = 0; e_err = '0;
    endtask

    task automatic model_step(input logic en, input logic h, input logic v, input logic [2:0] px);
        bit hf, hr, vf, bad;
        int c, r;
        if (!en) begin
            e_pv = 0;
            e_fs = 0;
            return;
        end
        hf = m_primed && m_ph && !h;
        hr = m_primed && !m_ph && h;
        vf = m_primed && m_pv && !v;
        c = m_col;
        r = m_row;
        bad = 0;
        if (m_lvl == 0) begin
            if (hf) begin c = 656; m_lvl = 1; end
        end else if (m_lvl == 1) begin
            if (hf && c != 656) m_lvl = 0;
            else if (vf && c == 0) begin r = 490; m_lvl = 2; end
        end else begin
            bad = (hf && c != 656) || (hr && c != 752) ||
                  (vf && !(r == 490 && c == 0)) || (!v && !(r == 490 || r == 491));
            if (bad) begin
                m_lvl = 0;
                if (m_err < 255) m_err++;
            end
        end
        e_lk  = (m_lvl == 2);
        e_col = e_lk ? 10'(c) : 10'd0;
        e_row = e_lk ? 10'(r) : 10'd0;
        e_pix = px;
        e_pv  = e_lk && c < 640 && r < 480;
        e_fs  = e_lk && c == 0 && r == 0;
        e_err = 8'(m_err);
        m_col = (c + 1) % 800;
        m_row = (c == 799) ? (r + 1) % 521 : r;
        m_ph = h; m_pv = v; m_primed = 1;
    endtask

    // Compare process: every negedge, DUT against the model.
    always @(negedge Clock) begin
        n_checks++;
        if ({oColumn, oRow, oPixel, oPixelValid, oFrameStart, oLocked, oErrorCount} !==
            {e_col, e_row, e_pix, e_pv, e_fs, e_lk, e_err}) begin
            n_errors++;
            $display("FAIL model t=%0t col %0d/%0d row %0d/%0d pix %0d/%0d vld %0b/%0b fs %0b/%0b lk %0b/%0b err %0d/%0d (actual/required)",
                     $time, oColumn, e_col, oRow, e_row, oPixel, e_pix, oPixelValid, e_pv,
                     oFrameStart, e_fs, oLocked, e_lk, oErrorCount, e_err);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    // Called at posedge+1; inputs are sampled on the next posedge.
    task automatic step(input logic en, input logic h, input logic v, input logic [2:0] px);
        Enable = en; iHorizontalSync = h; iVerticalSync = v; iPixel = px;
        @(posedge Clock);
        model_step(en, h, v, px);
        #1;
    endtask

    int tx_col, tx_row;
    int shift_row = -1;

    task automatic tx_cycle(input logic en);
        int s;
        logic h, v;
        logic [2:0] px;
        s  = (tx_row == shift_row) ? 1 : 0;
        h  = !(tx_col >= 656 + s && tx_col < 752 + s);
        v  = !(tx_row >= 490 && tx_row < 492);
        px = (tx_col == 10 && tx_row == 20) ? 3'b101 : 3'(tx_col ^ tx_row);
        step(en, h, v, px);
        if (en) begin
            tx_col++;
            if (tx_col == 800) begin
                tx_col = 0;
                tx_row = (tx_row + 1) % 521;
            end
        end
    endtask

    task automatic tx_run(input int n);
        for (int i = 0; i < n; i++) tx_cycle(1'b1);
    endtask

    initial begin
        int fs_cnt;
        Reset = 1'b0; Enable = 1'b0; iHorizontalSync = 1'b1; iVerticalSync = 1'b1; iPixel = '0;
        model_reset();
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b1;
        chk("reset_locked", 32'(oLocked), 0);
        chk("reset_errcnt", 32'(oErrorCount), 0);
        chk("reset_col",    32'(oColumn), 0);

        // Lock: HSync edge at (489,656), VSync edge at (490,0)
        tx_row = 489; tx_col = 600;
        tx_run(201);
        chk("lock_locked", 32'(oLocked), 1);
        chk("lock_row",    32'(oRow), 490);
        chk("lock_col",    32'(oColumn), 0);

        // 31 lines from (490,0) to the next (0,0)
        fs_cnt = 0;
        for (int i = 0; i < 24800; i++) begin
            tx_cycle(1'b1);
            if (oFrameStart === 1'b1) fs_cnt++;
        end
        chk("frame_start_now", 32'(oFrameStart), 1);
        chk("frame_start_cnt", 32'(fs_cnt), 1);

        // Enable low mid-line at (5,300)
        tx_run(4300);
        for (int i = 0; i < 50; i++) tx_cycle(1'b0);
        chk("en_low_col",   32'(oColumn), 300);
        chk("en_low_row",   32'(oRow), 5);
        chk("en_low_valid", 32'(oPixelValid), 0);

        // Marked pixel at (20,10)
        tx_run(11710);
        chk("pix_value", 32'(oPixel), 32'b101);
        chk("pix_col",   32'(oColumn), 10);
        chk("pix_row",   32'(oRow), 20);
        chk("pix_valid", 32'(oPixelValid), 1);
        chk("no_err_after_en", 32'(oErrorCount), 0);

        // HSync falling edge one column late on row 21
        shift_row = 21;
        tx_run(1447);
        chk("shift_locked", 32'(oLocked), 0);
        chk("shift_errcnt", 32'(oErrorCount), 1);
        tx_run(142);
        shift_row = -1;
        tx_row = 489; tx_col = 0;
        tx_run(801);
        chk("relock_locked", 32'(oLocked), 1);
        chk("relock_errcnt", 32'(oErrorCount), 1);

        // Asynchronous reset mid-frame
        tx_run(100);
        #2 Reset = 1'b0;
        model_reset();
        #1;
        chk("areset_locked", 32'(oLocked), 0);
        chk("areset_errcnt", 32'(oErrorCount), 0);
        chk("areset_col",    32'(oColumn), 0);
        chk("areset_row",    32'(oRow), 0);
        chk("areset_valid",  32'(oPixelValid), 0);
        chk("areset_pix",    32'(oPixel), 0);
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b1;
        tx_run(10);
        chk("post_reset_search", 32'(oLocked), 0);

        // 300 forced lock losses: lock, then an HSync edge at column 1
        for (int k = 0; k < 300; k++) begin
            step(1'b1, 1'b1, 1'b1, 3'd0);
            step(1'b1, 1'b0, 1'b1, 3'd0);
            for (int i = 0; i < 143; i++) step(1'b1, 1'b1, 1'b1, 3'd0);
            step(1'b1, 1'b1, 1'b0, 3'd0);
            step(1'b1, 1'b0, 1'b1, 3'd0);
            if (k == 0) chk("err_first", 32'(oErrorCount), 1);
        end
        chk("err_saturated", 32'(oErrorCount), 255);
        chk("err_unlocked",  32'(oLocked), 0);

        @(negedge Clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
